// File: rtl/ps2_key_if.sv
// ps2_key_if: raw PS/2 lines into the receiver and decoded key events out of it
interface ps2_key_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_code;
    logic       key_on;
    logic       key_ext;
    logic       frame_err;
    logic       busy;
    modport master (output ps2_clk, ps2_data, input key_code, key_on, key_ext, frame_err, busy);
    modport slave  (input ps2_clk, ps2_data, output key_code, key_on, key_ext, frame_err, busy);
endinterface

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 keyboard front-end producing one fixed-length strobe per new key press
module ps2_key_receiver #(
    parameter int FILTER_LEN      = 4,
    parameter int TIMEOUT         = 2000,
    parameter int PULSE_LEN       = 10,
    parameter int SUPPRESS_REPEAT = 1
) (
    input logic        clk,
    input logic        rst,
    ps2_key_if.slave   bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);
    typedef enum logic [1:0] {IDLE, RECV, DECODE} state_t;
    state_t          state_q, state_d;
    logic [1:0]      clk_s_q, clk_s_d, dat_s_q, dat_s_d;
    logic            filt_q, filt_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [9:0]      sh_q, sh_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            brk_q, brk_d, ext_q, ext_d, held_v_q, held_v_d;
    logic [8:0]      held_q, held_d;
    logic [7:0]      code_q, code_d;
    logic            kext_q, kext_d, err_q, err_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic            fall, dat, match;
    logic [7:0]      byte_v;
    always_comb begin
        clk_s_d  = {clk_s_q[0], bus.ps2_clk};
        dat_s_d  = {dat_s_q[0], bus.ps2_data};
        dat      = dat_s_q[1];
        // the filtered level only follows after FILTER_LEN consecutive disagreeing samples
        fcnt_d   = '0;
        filt_d   = filt_q;
        if (clk_s_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s_q[1];
            else fcnt_d = fcnt_q + 1'b1;
        end
        fall     = filt_q & ~filt_d;
        byte_v   = sh_q[7:0];
        match    = held_q == {ext_q, byte_v};
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sh_d     = sh_q;
        tcnt_d   = tcnt_q;
        brk_d    = brk_q;
        ext_d    = ext_q;
        held_d   = held_q;
        held_v_d = held_v_q;
        code_d   = code_q;
        kext_d   = kext_q;
        err_d    = 1'b0;
        pcnt_d   = pcnt_q != '0 ? pcnt_q - 1'b1 : '0;
        case (state_q)
            IDLE: if (fall && !dat) begin
                state_d  = RECV;
                bitcnt_d = '0;
                tcnt_d   = '0;
            end
            RECV: if (fall) begin
                sh_d     = {dat, sh_q[9:1]};
                bitcnt_d = bitcnt_q + 1'b1;
                tcnt_d   = '0;
                if (bitcnt_q == 4'd9) state_d = DECODE;
            end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end else tcnt_d = tcnt_q + 1'b1;
            DECODE: begin
                state_d = IDLE;
                if (!(^sh_q[8:0] && sh_q[9])) err_d = 1'b1;
                else if (byte_v == 8'hE0) ext_d = 1'b1;
                else if (byte_v == 8'hF0) brk_d = 1'b1;
                else if (brk_q) begin
                    if (match) held_v_d = 1'b0;
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end else if (SUPPRESS_REPEAT != 0 && held_v_q && match) ext_d = 1'b0;
                else begin
                    code_d   = byte_v;
                    kext_d   = ext_q;
                    held_d   = {ext_q, byte_v};
                    held_v_d = 1'b1;
                    ext_d    = 1'b0;
                    pcnt_d   = PW'(PULSE_LEN);
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            clk_s_q  <= '0;
            dat_s_q  <= '0;
            filt_q   <= 1'b0;
            fcnt_q   <= '0;
            bitcnt_q <= '0;
            sh_q     <= '0;
            tcnt_q   <= '0;
            brk_q    <= 1'b0;
            ext_q    <= 1'b0;
            held_q   <= '0;
            held_v_q <= 1'b0;
            code_q   <= '0;
            kext_q   <= 1'b0;
            err_q    <= 1'b0;
            pcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            clk_s_q  <= clk_s_d;
            dat_s_q  <= dat_s_d;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            bitcnt_q <= bitcnt_d;
            sh_q     <= sh_d;
            tcnt_q   <= tcnt_d;
            brk_q    <= brk_d;
            ext_q    <= ext_d;
            held_q   <= held_d;
            held_v_q <= held_v_d;
            code_q   <= code_d;
            kext_q   <= kext_d;
            err_q    <= err_d;
            pcnt_q   <= pcnt_d;
        end
    end
    assign bus.key_code  = code_q;
    assign bus.key_on    = pcnt_q != '0;
    assign bus.key_ext   = kext_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = state_q == RECV;
endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: directed and random PS/2 frames checked against a key-event model
module tb_ps2_key_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ps2_key_if bus ();
    ps2_key_receiver dut (.clk(clk), .rst(rst), .bus(bus.slave));
    int tests = 0;
    int fails = 0;
    logic [7:0] m_code;
    logic       m_ext, m_brk, m_extp, m_hv;
    logic [8:0] m_held;
    int         m_pulses = 0, m_errs = 0;
    int         seen_pulses = 0, seen_errs = 0, on_len = 0;
    logic       prev_on = 1'b0, prev_err = 1'b0;
    logic [7:0] prev_code = '0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask
    task automatic send_bits(input logic [10:0] f, input int n, input int hp);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = f[i];
            wclk(hp);
            bus.ps2_clk = 1'b0;
            wclk(hp);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask
    task automatic model_reset();
        m_code = '0; m_ext = 0; m_brk = 0; m_extp = 0; m_hv = 0; m_held = '0;
    endtask
    // one held key at a time: a make is new unless the same key is still held down
    task automatic model(input logic [7:0] b, input bit ok);
        if (!ok) m_errs++;
        else if (b == 8'hE0) m_extp = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (m_brk) begin
            if (m_hv && m_held == {m_extp, b}) m_hv = 0;
            m_brk = 0; m_extp = 0;
        end else if (m_hv && m_held == {m_extp, b}) m_extp = 0;
        else begin
            m_code = b; m_ext = m_extp; m_held = {m_extp, b}; m_hv = 1; m_extp = 0;
            m_pulses++;
        end
    endtask
    task automatic check_state(input string tag);
        chk({tag, "_code"}, bus.key_code, m_code);
        chk({tag, "_ext"}, bus.key_ext, m_ext);
        chk({tag, "_pulses"}, seen_pulses, m_pulses);
        chk({tag, "_errs"}, seen_errs, m_errs);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask
    task automatic send(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0, input int hp = 20);
        logic [10:0] f;
        f = {~bad_stop, ~^b ^ bad_par, b, 1'b0};
        send_bits(f, 11, hp);
        wclk(30);
        model(b, !bad_par && !bad_stop);
        check_state("frame");
    endtask
    always @(negedge clk) begin
        if (rst) begin
            on_len = 0; prev_on = 0; prev_err = 0; prev_code = '0;
        end else begin
            if (prev_on && !bus.key_on) begin
                chk("key_on_len", on_len, 10);
                on_len = 0;
            end
            if (bus.key_on) on_len++;
            if (bus.key_on && !prev_on) seen_pulses++;
            else chk("code_stable", bus.key_code, prev_code);
            if (prev_err) chk("err_width", bus.frame_err, 0);
            if (bus.frame_err && !prev_err) seen_errs++;
            prev_on = bus.key_on; prev_err = bus.frame_err; prev_code = bus.key_code;
        end
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        bit bp, bs;
        logic [7:0] b;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        model_reset();
        wclk(3);
        #1;
        chk("rst_code", bus.key_code, 0);
        chk("rst_on", bus.key_on, 0);
        chk("rst_ext", bus.key_ext, 0);
        chk("rst_err", bus.frame_err, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        wclk(20);
        send(8'h16);
        chk("t1_code", bus.key_code, 8'h16);
        chk("t1_pulses", seen_pulses, 1);
        send(8'h1E, 1, 0);
        send(8'h1E, 0, 1);
        chk("t2_code", bus.key_code, 8'h16);
        chk("t2_errs", seen_errs, 2);
        send(8'h26); send(8'h26); send(8'h26);
        chk("t3_single", seen_pulses, 2);
        send(8'hF0); send(8'h26);
        chk("t3_break", seen_pulses, 2);
        send(8'h26);
        chk("t3_again", seen_pulses, 3);
        send(8'hE0); send(8'h75);
        chk("t4_code", bus.key_code, 8'h75);
        chk("t4_ext", bus.key_ext, 1);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("t4_brk", seen_pulses, 4);
        send(8'h45);
        chk("t4_code2", bus.key_code, 8'h45);
        chk("t4_ext2", bus.key_ext, 0);
        send_bits({2'b11, 8'h16, 1'b0}, 5, 20);
        chk("t5_busy_mid", bus.busy, 1);
        wclk(2100);
        m_errs++;
        check_state("t5_timeout");
        send(8'h1E);
        chk("t5_code", bus.key_code, 8'h1E);
        send_bits({2'b11, 8'h16, 1'b0}, 5, 20);
        rst = 1'b1;
        #1;
        chk("t6_code", bus.key_code, 0);
        chk("t6_on", bus.key_on, 0);
        chk("t6_busy", bus.busy, 0);
        model_reset();
        wclk(3);
        rst = 1'b0;
        wclk(20);
        send(8'h45);
        chk("t6_code2", bus.key_code, 8'h45);
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 5))
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'h16;
                3: b = 8'h1E;
                4: b = 8'h26;
                default: b = 8'($urandom);
            endcase
            bp = $urandom_range(0, 9) == 0;
            bs = $urandom_range(0, 19) == 0;
            send(b, bp, bs, $urandom_range(10, 30));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
